// File: rtl/param_cache.sv
// param_cache: N-way set-associative, write-back, write-allocate cache with
// a 256-bit line, invalid-way-first victim choice and tree pseudo-LRU.
// Optional performance counters are built when PARAM_CACHE_PERF_CNT_EN is
// defined; otherwise hit_count/miss_count are tied to zero.
module param_cache #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_byte_enable,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int SETS  = 2 ** S_INDEX;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {ST_CHECK, ST_RESP, ST_WB, ST_FILL} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [255:0]        r_data  [NUM_WAYS][SETS];
    logic [S_TAG-1:0]    r_tag   [NUM_WAYS][SETS];
    logic [NUM_WAYS-1:0] r_valid [SETS];
    logic [NUM_WAYS-1:0] r_dirty [SETS];
    logic [NUM_WAYS-2:0] r_plru  [SETS];
    logic [WAY_W-1:0]    r_victim;
    logic                r_from_fill;
    logic [255:0]        r_rdata;

    logic [S_TAG-1:0]    w_tag;
    logic [S_INDEX-1:0]  w_index;
    logic                w_req;
    logic [NUM_WAYS-1:0] w_hit_vec;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [255:0]        w_hit_line;
    logic [255:0]        w_merged;
    logic [NUM_WAYS-2:0] w_plru_cur;
    logic [NUM_WAYS-2:0] w_plru_upd;
    logic [WAY_W-1:0]    w_plru_way;
    logic [WAY_W-1:0]    w_node;
    logic [WAY_W-1:0]    w_victim;
    logic                w_inv_found;
    logic                w_victim_dirty;
    logic                w_unused;

    assign w_tag      = mem_address[31:S_OFFSET+S_INDEX];
    assign w_index    = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign w_req      = mem_read | mem_write;
    assign w_hit_line = r_data[w_hit_way][w_index];
    assign w_unused   = ^mem_address[S_OFFSET-1:0];
    assign mem_rdata  = r_rdata;
    assign mem_resp   = (r_state == ST_RESP);

    // Tag compare, byte merge and victim choice for the addressed set.
    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_hit_vec   = '0;
        w_hit_way   = '0;
        w_victim    = w_plru_way;
        w_inv_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_index][w] && (r_tag[w][w_index] == w_tag);
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
            if (!w_inv_found && !r_valid[w_index][w]) begin
                w_victim    = WAY_W'(w);
                w_inv_found = 1'b1;
            end
        end
        w_hit          = |w_hit_vec;
        w_victim_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];
        for (int i = 0; i < 32; i++) begin
            w_merged[i*8 +: 8] = mem_byte_enable[i] ? mem_wdata[i*8 +: 8] : w_hit_line[i*8 +: 8];
        end
    end

    // PLRU tree: the root decides way bit 0, each lower level the next bit.
    // A node bit names the subtree holding the next victim.
    always_comb begin
        w_plru_cur = r_plru[w_index];
        w_plru_way = '0;
        w_node     = '0;
        for (int k = 0; k < WAY_W; k++) begin
            w_plru_way[k] = w_plru_cur[w_node];
            w_node = (w_node << 1) + WAY_W'(1) + WAY_W'(w_plru_cur[w_node]);
        end
        w_plru_upd = w_plru_cur;
        w_node     = '0;
        for (int k = 0; k < WAY_W; k++) begin
            w_plru_upd[w_node] = ~w_hit_way[k];
            w_node = (w_node << 1) + WAY_W'(1) + WAY_W'(w_hit_way[k]);
        end
    end

    // Next-state and physical-memory request decode.
    always_comb begin
        w_state_next = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            ST_CHECK: begin
                if (w_req) begin
                    if (w_hit)               w_state_next = ST_RESP;
                    else if (w_victim_dirty) w_state_next = ST_WB;
                    else                     w_state_next = ST_FILL;
                end
            end
            ST_RESP: w_state_next = ST_CHECK;
            ST_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_victim][w_index], w_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[r_victim][w_index];
                if (pmem_resp) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) w_state_next = ST_CHECK;
            end
            default: w_state_next = ST_CHECK;
        endcase
    end

    // State register plus valid/dirty/PLRU bookkeeping and read-data capture.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CHECK;
            r_rdata     <= '0;
            r_victim    <= '0;
            r_from_fill <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_CHECK: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_plru[w_index] <= w_plru_upd;
                            r_from_fill     <= 1'b0;
                            if (mem_write) r_dirty[w_index][w_hit_way] <= 1'b1;
                            else           r_rdata <= w_hit_line;
                        end else begin
                            r_victim <= w_victim;
                        end
                    end
                end
                ST_FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= 1'b0;
                        r_from_fill                <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tag storage: write hits merge bytes, fills replace the victim.
    // NOTE: data/tag arrays carry no reset; cleared valid bits make their contents unobservable.
    always_ff @(posedge clk) begin
        if (r_state == ST_CHECK && w_req && w_hit && mem_write) begin
            r_data[w_hit_way][w_index] <= w_merged;
        end
        if (r_state == ST_FILL && pmem_resp) begin
            r_data[r_victim][w_index] <= pmem_rdata;
            r_tag[r_victim][w_index]  <= w_tag;
        end
    end

`ifdef PARAM_CACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating counters: first-check hits and miss entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_CHECK) begin
            if (w_state_next == ST_RESP && !r_from_fill && r_hit_count != '1)
                r_hit_count <= r_hit_count + 32'd1;
            if ((w_state_next == ST_WB || w_state_next == ST_FILL) && r_miss_count != '1)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_param_cache.sv
// Directed testbench for param_cache (default 4-way, 16-set build) with a
// behavioural line memory that answers two cycles after each request.
module tb_param_cache;

`ifdef PARAM_CACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_byte_enable;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp  = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    param_cache dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } xact_t;

    xact_t        log_q[$];
    logic [255:0] bmem [logic [31:0]];
    int           n_vec = 0;
    int           n_err = 0;
    int           lat_cnt = 0;
    int           act_cnt = 0;
    bit           mem_hold = 1'b0;
    bit           overlap = 1'b0;
    bit           misalign = 1'b0;

    // Memory model: answers each request on its second observed cycle.
    always @(negedge clk) begin
        if (pmem_read || pmem_write) act_cnt = act_cnt + 1;
        if (pmem_read && pmem_write) overlap = 1'b1;
        if ((pmem_read || pmem_write) && pmem_address[4:0] != 5'd0) misalign = 1'b1;
        if (!pmem_resp && (pmem_read || pmem_write) && !mem_hold) begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt == 2) begin
                lat_cnt   = 0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    bmem[pmem_address] = pmem_wdata;
                    log_q.push_back('{1'b1, pmem_address, pmem_wdata});
                end else begin
                    pmem_rdata = bmem.exists(pmem_address) ? bmem[pmem_address] : '0;
                    log_q.push_back('{1'b0, pmem_address, pmem_rdata});
                end
            end
        end else begin
            pmem_resp = 1'b0;
            if (!(pmem_read || pmem_write)) lat_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU transaction, issued on a falling edge; returns cycles to mem_resp.
    task automatic do_req(input string tag, input logic [31:0] a, input bit wr,
                          input logic [31:0] be, input logic [255:0] wd,
                          output int cyc, output logic [255:0] rd);
        mem_address     = a;
        mem_read        = !wr;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_resp && cyc < 60);
        check({tag, "_resp"}, mem_resp, 1'b1);
        rd        = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] rd;
    int           cyc;

    initial begin
        line_a = {{28{8'hAA}}, 32'h1234_5678};
        line_b = {{16{8'hBB}}, {8{8'h5A}}, {8{8'hBB}}};
        bmem[32'h0000_0040] = {32{8'hAA}};
        bmem[32'h0000_0240] = {32{8'hBB}};
        bmem[32'h0000_0440] = {32{8'hCC}};
        bmem[32'h0000_0640] = {32{8'hDD}};
        bmem[32'h0000_0840] = {32{8'hEE}};

        rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_resp",  mem_resp, 1'b0);
        check("rst_rdata", mem_rdata, '0);
        check("rst_pread", pmem_read, 1'b0);
        check("rst_pwrite", pmem_write, 1'b0);
        check("rst_paddr", pmem_address, '0);
        check("rst_pwdata", pmem_wdata, '0);
        check("rst_hits",  hit_count, '0);
        check("rst_miss",  miss_count, '0);
        rst = 1'b0;
        @(negedge clk);

        // Cold read miss
        log_q.delete();
        do_req("rd_a1", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a1_lat",  cyc, 4);
        check("rd_a1_data", rd, {32{8'hAA}});
        check("rd_a1_nfill", log_q.size(), 1);
        if (log_q.size() > 0) check("rd_a1_paddr", log_q[0].addr, 32'h40);
        check("rd_a1_miss", miss_count, PERF ? 32'd1 : 32'd0);
        check("rd_a1_hits", hit_count, '0);

        // Read hit: one cycle, no memory traffic
        act_cnt = 0;
        do_req("rd_a2", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a2_lat",  cyc, 1);
        check("rd_a2_pmem", act_cnt, 0);
        check("rd_a2_hits", hit_count, PERF ? 32'd1 : 32'd0);

        // Byte-masked write hit, then read back
        do_req("wr_a", 32'h40, 1'b1, 32'h0000_000F, {224'h0, 32'h1234_5678}, cyc, rd);
        check("wr_a_lat", cyc, 1);
        do_req("rd_a3", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a3_data", rd, line_a);

        // Fill the remaining ways of set 2, dirtying the way-1 line
        do_req("rd_b", 32'h240, 1'b0, '0, '0, cyc, rd);
        check("rd_b_lat", cyc, 4);
        do_req("wr_b", 32'h240, 1'b1, 32'h0000_FF00, {32{8'h5A}}, cyc, rd);
        do_req("rd_c", 32'h440, 1'b0, '0, '0, cyc, rd);
        check("rd_c_lat", cyc, 4);
        do_req("rd_d", 32'h640, 1'b0, '0, '0, cyc, rd);
        check("rd_d_data", rd, {32{8'hDD}});
        do_req("rd_a4", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a4_lat", cyc, 1);

        // Fifth line: PLRU victim is way 1 (dirty), written back before the fill
        log_q.delete();
        overlap = 1'b0;
        do_req("rd_e", 32'h840, 1'b0, '0, '0, cyc, rd);
        check("rd_e_lat",  cyc, 7);
        check("rd_e_data", rd, {32{8'hEE}});
        check("ev_nxact",  log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("ev_first_wr", log_q[0].wr, 1'b1);
            check("ev_wb_addr",  log_q[0].addr, 32'h240);
            check("ev_wb_data",  log_q[0].data, line_b);
            check("ev_second_rd", log_q[1].wr, 1'b0);
            check("ev_fill_addr", log_q[1].addr, 32'h840);
        end
        check("no_overlap", overlap, 1'b0);

        do_req("rd_a5", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a5_lat",  cyc, 1);
        check("rd_a5_data", rd, line_a);
        do_req("rd_c2", 32'h440, 1'b0, '0, '0, cyc, rd);
        check("rd_c2_lat",  cyc, 1);
        check("rd_c2_data", rd, {32{8'hCC}});
        check("end_hits", hit_count, PERF ? 32'd7 : 32'd0);
        check("end_miss", miss_count, PERF ? 32'd5 : 32'd0);

        // Reset while a fill is outstanding
        mem_hold    = 1'b1;
        mem_address = 32'hA40;
        mem_read    = 1'b1;
        for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
        check("mid_fill_req",  pmem_read, 1'b1);
        check("mid_fill_addr", pmem_address, 32'hA40);
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        check("mid_rst_pread",  pmem_read, 1'b0);
        check("mid_rst_pwrite", pmem_write, 1'b0);
        check("mid_rst_rdata",  mem_rdata, '0);
        check("mid_rst_miss",   miss_count, '0);
        rst      = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);

        log_q.delete();
        do_req("rd_x", 32'hA40, 1'b0, '0, '0, cyc, rd);
        check("rd_x_lat",  cyc, 4);
        check("rd_x_nfill", log_q.size(), 1);
        check("rd_x_data", rd, '0);
        do_req("rd_a6", 32'h40, 1'b0, '0, '0, cyc, rd);
        check("rd_a6_lat",  cyc, 4);
        check("rd_a6_data", rd, {32{8'hAA}});
        check("no_overlap2", overlap, 1'b0);
        check("aligned",     misalign, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_cache.md
# param_cache

Parametrised N-way set-associative write-back, write-allocate cache with an integrated control FSM, tree pseudo-LRU replacement and a 256-bit line. It sits between the CPU-side 256-bit line interface (bus adapter) and the physical-memory line port. It generalises the fixed 4-way, 16-set datapath/control pair to a configurable way count and set count, adding invalid-way-first victim selection.

## Interface
- `S_OFFSET`, 5, byte-offset bits; fixed, line = 256 bits.
- `S_INDEX`, 4, index bits; sets = 2**S_INDEX (1..8 legal).
- `NUM_WAYS`, 4, associativity; power of two, 2..16.
- `S_TAG`, 32-S_OFFSET-S_INDEX, tag bits (derived).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `mem_address` in 32: CPU request address.
- `mem_read` in 1: read request, held until `mem_resp`.
- `mem_write` in 1: write request, held until `mem_resp`.
- `mem_byte_enable` in 32: per-byte write enable for the line.
- `mem_wdata` in 256: write line data.
- `mem_rdata` out 256: read line data, registered, valid with `mem_resp`.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_address` out 32: line address, low 5 bits always 0.
- `pmem_read` out 1: line fill request, held until `pmem_resp`.
- `pmem_write` out 1: writeback request, held until `pmem_resp`.
- `pmem_wdata` out 256: victim line data.
- `pmem_rdata` in 256: fill data, valid with `pmem_resp`.
- `pmem_resp` in 1: physical memory completion.
- `hit_count`, `miss_count` out 32 each: performance counters (see Configuration).

## Operation
- Address split: tag = `[31:S_OFFSET+S_INDEX]`, index = `[S_OFFSET+S_INDEX-1:S_OFFSET]`.
- Arrays per way: data, tag, valid, dirty, held in flops with combinational read. Each set has a PLRU tree of NUM_WAYS-1 bits.
- Hit: valid & tag match. At most one way hits.
- Victim: lowest-indexed invalid way; if all ways are valid, the PLRU way. Victim selection is latched on the CHECK→WB/FILL edge and stays stable through the miss.
- FSM states: CHECK, RESP, WB, FILL.
  - CHECK, no request: stay.
  - CHECK, hit: go to RESP.
    - Read: register the hit line into `mem_rdata`.
    - Write: merge bytes where `mem_byte_enable[i]`=1 and set dirty=1.
    - Update PLRU to point away from the hit way.
  - CHECK, miss: go to WB if the victim is valid and dirty, else go to FILL.
  - WB: `pmem_write`=1, `pmem_address`={victim tag, index, 0}, `pmem_wdata`=victim line. On `pmem_resp`, go to FILL.
  - FILL: `pmem_read`=1, `pmem_address`={req tag, index, 0}. On `pmem_resp`, write `pmem_rdata` and the tag into the victim, set valid=1, dirty=0, then go to CHECK. The re-check hits.
  - RESP: `mem_resp`=1 for exactly one cycle, then go to CHECK. Requests are ignored in RESP.
- `mem_read` and `mem_write` both high: treated as a write.
- `pmem_resp` outside WB/FILL: ignored.

## Timing
- Reset values:
  - State=CHECK.
  - `mem_resp`=0, `mem_rdata`=0, `pmem_read`=0, `pmem_write`=0.
  - `pmem_address`=0, `pmem_wdata`=0, counters=0.
  - All valid, dirty and PLRU bits cleared. Data and tag arrays are not reset.
- Hit latency: request presented in cycle t → `mem_resp` in cycle t+1.
- Clean miss: `mem_resp` arrives 2 cycles after `pmem_resp` of FILL.
- Dirty miss: WB, then FILL, then CHECK, then RESP.
- `pmem_read` and `pmem_write` are never high together. Each stays high continuously until its `pmem_resp`, deasserting in the following cycle.
- Requester must keep its request stable until `mem_resp`. It may issue a new request in the cycle after `mem_resp`.
- Reset mid-miss: the FSM returns to CHECK on that edge and `pmem_*` requests drop the next cycle. A partially filled line is never marked valid.

## Configuration
- `PARAM_CACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on every CHECK→RESP transition whose first CHECK cycle hit.
  - `miss_count` increments once per CHECK→WB/FILL transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset, then read 0x0000_0040 → FILL with `pmem_address`=0x0000_0040; return 0xAA..AA → `mem_rdata`=0xAA..AA, `miss_count`=1.
- Repeat the read of 0x0000_0040 → `mem_resp` 1 cycle after the request, no `pmem_*` activity, `hit_count`=1.
- Write 0x0000_0040 with `mem_byte_enable`=0x0000_000F, `mem_wdata` low word 0x12345678 → a re-read returns low word 0x12345678 and the remaining bytes 0xAA.
- NUM_WAYS=4: fill 5 lines mapping to set 2, first touching the way-0 line again. The way-0 line survives; the PLRU victim is the way-1 line, written back with its dirty data before the fill.
- Dirty eviction: `pmem_write` is seen before `pmem_read`, never overlapping, with `pmem_address`={old tag, index, 0}.
- Assert `rst` during FILL → `pmem_read` drops the next cycle; the line misses again on the subsequent read.
